// File: rtl/binary_bbox_overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : binary_bbox_overlay_pkg
// Desc     : Shared constants and FSM states for the binary bbox overlay.
// Revision : 1.0
// ============================================================================
package binary_bbox_overlay_pkg;

    localparam int          c_COORD_W   = 12;
    localparam logic [23:0] c_BOX_COLOR = 24'hFF0000;
    localparam int          c_PANEL_W   = 480;
    localparam int          c_PANEL_H   = 272;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/binary_bbox_overlay_accum.sv
`default_nettype none
// ============================================================================
// Module   : bbox_accum
// Desc     : Min/max/count accumulator of flagged pixel coordinates.
// Revision : 1.0
// ============================================================================
module bbox_accum
    import binary_bbox_overlay_pkg::*;
#(
    parameter int COORD_W = c_COORD_W,
    parameter int CNT_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_seed,
    input  logic               i_update,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [COORD_W-1:0] o_x_min,
    output logic [COORD_W-1:0] o_x_max,
    output logic [COORD_W-1:0] o_y_min,
    output logic [COORD_W-1:0] o_y_max,
    output logic [CNT_W-1:0]   o_cnt
);

    logic [COORD_W-1:0] r_x_min, r_x_max, r_y_min, r_y_max;
    logic [CNT_W-1:0]   r_cnt;

    // Seeding takes priority over clearing so a pixel in the clear cycle is kept.
    always_ff @(posedge clk) begin
        if (rst || (i_clear && !i_seed)) begin
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
            r_cnt   <= '0;
        end else if (i_seed) begin
            r_x_min <= i_x;
            r_x_max <= i_x;
            r_y_min <= i_y;
            r_y_max <= i_y;
            r_cnt   <= CNT_W'(1);
        end else if (i_update) begin
            if (i_x < r_x_min) r_x_min <= i_x;
            if (i_x > r_x_max) r_x_max <= i_x;
            if (i_y < r_y_min) r_y_min <= i_y;
            if (i_y > r_y_max) r_y_max <= i_y;
            if (r_cnt != '1)   r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_x_min = r_x_min;
    assign o_x_max = r_x_max;
    assign o_y_min = r_y_min;
    assign o_y_max = r_y_max;
    assign o_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/binary_bbox_overlay.sv
`default_nettype none
// ============================================================================
// Module   : binary_bbox_overlay
// Desc     : Bounding box of flagged pixels per frame, drawn over next frame.
// Revision : 1.0
// ============================================================================
module binary_bbox_overlay
    import binary_bbox_overlay_pkg::*;
#(
    parameter int          COORD_W    = c_COORD_W,
    parameter int          CNT_W      = 20,
    parameter int          MIN_PIXELS = 64,
    parameter int          BORDER     = 2,
    parameter logic [23:0] BOX_COLOR  = c_BOX_COLOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_de,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [23:0]        i_data,
    input  logic               i_flag,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [23:0]        o_data,
    output logic               o_box_valid,
    output logic [COORD_W-1:0] o_x_min,
    output logic [COORD_W-1:0] o_x_max,
    output logic [COORD_W-1:0] o_y_min,
    output logic [COORD_W-1:0] o_y_max,
    output logic [CNT_W-1:0]   o_pix_cnt
);

    localparam logic [COORD_W-1:0] c_BORDER     = COORD_W'(BORDER);
    localparam logic [CNT_W-1:0]   c_MIN_PIXELS = CNT_W'(MIN_PIXELS);

    state_t             r_state;
    logic               r_vs_d;
    logic               r_hs, r_vs, r_de;
    logic [COORD_W-1:0] r_x, r_y;
    logic [23:0]        r_data;
    logic               r_box_valid;
    logic [COORD_W-1:0] r_x_min, r_x_max, r_y_min, r_y_max;
    logic [CNT_W-1:0]   r_pix_cnt;

    logic               w_vs_rise, w_pix;
    logic               w_clear, w_seed, w_update;
    logic [COORD_W-1:0] w_acc_x_min, w_acc_x_max, w_acc_y_min, w_acc_y_max;
    logic [CNT_W-1:0]   w_acc_cnt;
    logic               w_in_box, w_near_edge, w_overlay;

    assign w_vs_rise = i_vs && !r_vs_d;
    assign w_pix     = i_de && i_flag;

    always_comb begin
        w_clear  = 1'b0;
        w_seed   = 1'b0;
        w_update = 1'b0;
        case (r_state)
            ST_IDLE:  w_clear  = w_vs_rise;
            ST_ACCUM: w_update = w_pix;
            ST_LATCH: begin
                w_clear = 1'b1;
                w_seed  = w_pix;
            end
            default: ;
        endcase
    end

    bbox_accum #(
        .COORD_W (COORD_W),
        .CNT_W   (CNT_W)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_seed   (w_seed),
        .i_update (w_update),
        .i_x      (i_x),
        .i_y      (i_y),
        .o_x_min  (w_acc_x_min),
        .o_x_max  (w_acc_x_max),
        .o_y_min  (w_acc_y_min),
        .o_y_max  (w_acc_y_max),
        .o_cnt    (w_acc_cnt)
    );

    // Edge distances are only meaningful inside the box, which keeps them non-negative.
    assign w_in_box    = (i_x >= r_x_min) && (i_x <= r_x_max) &&
                         (i_y >= r_y_min) && (i_y <= r_y_max);
    assign w_near_edge = ((i_x - r_x_min) < c_BORDER) || ((r_x_max - i_x) < c_BORDER) ||
                         ((i_y - r_y_min) < c_BORDER) || ((r_y_max - i_y) < c_BORDER);
    assign w_overlay   = r_box_valid && i_de && w_in_box && w_near_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_vs_d      <= 1'b0;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_de        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_data      <= '0;
            r_box_valid <= 1'b0;
            r_x_min     <= '0;
            r_x_max     <= '0;
            r_y_min     <= '0;
            r_y_max     <= '0;
            r_pix_cnt   <= '0;
        end else begin
            r_vs_d <= i_vs;
            r_hs   <= i_hs;
            r_vs   <= i_vs;
            r_de   <= i_de;
            r_x    <= i_x;
            r_y    <= i_y;
            r_data <= w_overlay ? BOX_COLOR : i_data;
            case (r_state)
                ST_IDLE:  if (w_vs_rise) r_state <= ST_ACCUM;
                ST_ACCUM: if (w_vs_rise) r_state <= ST_LATCH;
                ST_LATCH: begin
                    r_x_min     <= w_acc_x_min;
                    r_x_max     <= w_acc_x_max;
                    r_y_min     <= w_acc_y_min;
                    r_y_max     <= w_acc_y_max;
                    r_pix_cnt   <= w_acc_cnt;
                    r_box_valid <= (w_acc_cnt >= c_MIN_PIXELS);
                    r_state     <= ST_ACCUM;
                end
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_hs        = r_hs;
    assign o_vs        = r_vs;
    assign o_de        = r_de;
    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_data      = r_data;
    assign o_box_valid = r_box_valid;
    assign o_x_min     = r_x_min;
    assign o_x_max     = r_x_max;
    assign o_y_min     = r_y_min;
    assign o_y_max     = r_y_max;
    assign o_pix_cnt   = r_pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_binary_bbox_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_bbox_overlay
// Desc     : Scoreboard bench; two instances (MIN_PIXELS 64 and 1) share stimulus.
// Revision : 1.0
// ============================================================================
module tb_binary_bbox_overlay;

    localparam int c_B   = 2;
    localparam int c_SAT = (1 << 20) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_hs, i_vs, i_de, i_flag;
    logic [11:0] i_x, i_y;
    logic [23:0] i_data;

    logic        a_hs, a_vs, a_de, a_box_valid;
    logic [11:0] a_x, a_y, a_x_min, a_x_max, a_y_min, a_y_max;
    logic [23:0] a_data;
    logic [19:0] a_pix_cnt;
    logic        b_hs, b_vs, b_de, b_box_valid;
    logic [11:0] b_x, b_y, b_x_min, b_x_max, b_y_min, b_y_max;
    logic [23:0] b_data;
    logic [19:0] b_pix_cnt;

    always #5 clk = ~clk;

    binary_bbox_overlay #(.MIN_PIXELS(64)) dut_a (
        .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
        .i_data(i_data), .i_flag(i_flag), .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_x(a_x),
        .o_y(a_y), .o_data(a_data), .o_box_valid(a_box_valid), .o_x_min(a_x_min),
        .o_x_max(a_x_max), .o_y_min(a_y_min), .o_y_max(a_y_max), .o_pix_cnt(a_pix_cnt));

    binary_bbox_overlay #(.MIN_PIXELS(1)) dut_b (
        .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
        .i_data(i_data), .i_flag(i_flag), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_x(b_x),
        .o_y(b_y), .o_data(b_data), .o_box_valid(b_box_valid), .o_x_min(b_x_min),
        .o_x_max(b_x_max), .o_y_min(b_y_min), .o_y_max(b_y_max), .o_pix_cnt(b_pix_cnt));

    typedef struct packed {
        logic        hs, vs, de;
        logic [11:0] x, y;
        logic [23:0] da, db;
        logic        va, vb;
        logic [11:0] xmin, xmax, ymin, ymax;
        logic [19:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: frames delimited by rising vs, box shown one frame late.
    bit m_started, m_pending, m_prev_vs;
    int acc_xmin, acc_xmax, acc_ymin, acc_ymax, acc_cnt;
    int box_xmin, box_xmax, box_ymin, box_ymax, box_cnt;
    bit box_va, box_vb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit ovl(int x, int y);
        if (x < box_xmin || x > box_xmax || y < box_ymin || y > box_ymax) return 0;
        return (x - box_xmin < c_B) || (box_xmax - x < c_B) ||
               (y - box_ymin < c_B) || (box_ymax - y < c_B);
    endfunction

    task automatic acc_clear();
        acc_xmin = 4095; acc_xmax = 0; acc_ymin = 4095; acc_ymax = 0; acc_cnt = 0;
    endtask

    task automatic acc_add(int x, int y);
        if (x < acc_xmin) acc_xmin = x;
        if (x > acc_xmax) acc_xmax = x;
        if (y < acc_ymin) acc_ymin = y;
        if (y > acc_ymax) acc_ymax = y;
        if (acc_cnt < c_SAT) acc_cnt++;
    endtask

    task automatic model_step();
        exp_t e;
        int   x = int'(i_x);
        int   y = int'(i_y);
        bit   pix  = i_de && i_flag;
        bit   rise = i_vs && !m_prev_vs;
        e = '0;
        if (rst) begin
            m_started = 0; m_pending = 0; m_prev_vs = 0;
            box_xmin = 0; box_xmax = 0; box_ymin = 0; box_ymax = 0; box_cnt = 0;
            box_va = 0; box_vb = 0;
            acc_clear();
        end else begin
            e.hs = i_hs; e.vs = i_vs; e.de = i_de; e.x = i_x; e.y = i_y;
            e.da = (box_va && i_de && ovl(x, y)) ? 24'hFF0000 : i_data;
            e.db = (box_vb && i_de && ovl(x, y)) ? 24'hFF0000 : i_data;
            if (m_pending) begin
                box_xmin = acc_xmin; box_xmax = acc_xmax;
                box_ymin = acc_ymin; box_ymax = acc_ymax; box_cnt = acc_cnt;
                box_va = (acc_cnt >= 64);
                box_vb = (acc_cnt >= 1);
                acc_clear();
                m_pending = 0;
                if (pix) acc_add(x, y);
            end else if (m_started) begin
                if (pix) acc_add(x, y);
                if (rise) m_pending = 1;
            end else if (rise) begin
                m_started = 1;
                acc_clear();
            end
            m_prev_vs = i_vs;
            e.va = box_va; e.vb = box_vb;
            e.xmin = 12'(box_xmin); e.xmax = 12'(box_xmax);
            e.ymin = 12'(box_ymin); e.ymax = 12'(box_ymax); e.cnt = 20'(box_cnt);
        end
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic hs, input logic vs, input logic de,
                       input int x, input int y, input logic fl);
        @(negedge clk);
        rst = r; i_hs = hs; i_vs = vs; i_de = de;
        i_x = 12'(x); i_y = 12'(y); i_data = 24'($urandom); i_flag = fl;
        model_step();
    endtask

    function automatic logic flag_of(int mode, int x, int y, int prob);
        case (mode)
            1:       return (x >= 100 && x <= 199 && y >= 50 && y <= 99);
            2:       return (y == 1 && x < 10);
            3:       return (x == 0 && y == 0);
            4:       return ($urandom_range(0, 99) < prob);
            5:       return (x >= 2 && x <= 11 && y >= 1 && y <= 8);
            default: return 1'b0;
        endcase
    endfunction

    // Flag is randomised during blanking to confirm it is gated by de.
    task automatic frame(input int x0, input int x1, input int y0, input int y1,
                         input int mode, input int prob, input int rst_line);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, x1, y1, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 2; k++) cyc(0, 0, 0, 0, x1, y1, 1'($urandom_range(0, 1)));
        for (int y = y0; y <= y1; y++) begin
            cyc(y == rst_line, 1, 0, 0, x0, y, 1'($urandom_range(0, 1)));
            if (y == rst_line) begin
                @(posedge clk); #1;
                chk("reset_valid", a_box_valid, 0);
                chk("reset_data", a_data, 0);
                chk("reset_xmin", a_x_min, 0);
            end
            cyc(0, 1, 0, 0, x0, y, 1'($urandom_range(0, 1)));
            cyc(0, 0, 0, 0, x0, y, 1'($urandom_range(0, 1)));
            for (int x = x0; x <= x1; x++) cyc(0, 0, 0, 1, x, y, flag_of(mode, x, y, prob));
            cyc(0, 0, 0, 0, x1, y, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("video_a", {a_hs, a_vs, a_de, a_x, a_y}, {e.hs, e.vs, e.de, e.x, e.y});
                chk("video_b", {b_hs, b_vs, b_de, b_x, b_y}, {e.hs, e.vs, e.de, e.x, e.y});
                chk("data_a", a_data, e.da);
                chk("data_b", b_data, e.db);
                chk("valid_a", a_box_valid, e.va);
                chk("valid_b", b_box_valid, e.vb);
                chk("box_a", {a_x_min, a_x_max, a_y_min, a_y_max}, {e.xmin, e.xmax, e.ymin, e.ymax});
                chk("box_b", {b_x_min, b_x_max, b_y_min, b_y_max}, {e.xmin, e.xmax, e.ymin, e.ymax});
                chk("cnt_a", a_pix_cnt, e.cnt);
                chk("cnt_b", b_pix_cnt, e.cnt);
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int bx, by, sel;
        rst = 1'b1; i_hs = 0; i_vs = 0; i_de = 0; i_x = 0; i_y = 0; i_data = 0; i_flag = 0;
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("reset_state", {a_box_valid, a_data, a_pix_cnt}, 0);

        frame(98, 201, 48, 101, 1, 0, -1);
        frame(98, 201, 48, 101, 1, 0, -1);
        frame(0, 15, 0, 5, 2, 0, -1);
        @(posedge clk); #1;
        chk("region_valid", a_box_valid, 1);
        chk("region_box", {a_x_min, a_x_max, a_y_min, a_y_max}, {12'd100, 12'd199, 12'd50, 12'd99});
        chk("region_cnt", a_pix_cnt, 20'd5000);

        frame(0, 15, 0, 5, 0, 0, -1);
        @(posedge clk); #1;
        chk("ten_valid_a", a_box_valid, 0);
        chk("ten_valid_b", b_box_valid, 1);
        chk("ten_cnt", b_pix_cnt, 20'd10);

        frame(0, 7, 0, 3, 3, 0, -1);
        @(posedge clk); #1;
        chk("empty_valid", {a_box_valid, b_box_valid}, 0);
        chk("empty_box", {a_x_min, a_x_max, a_y_min, a_y_max}, {12'd4095, 12'd0, 12'd4095, 12'd0});

        frame(0, 7, 0, 3, 3, 0, -1);
        @(posedge clk); #1;
        chk("single_valid_b", b_box_valid, 1);
        chk("single_box", {b_x_min, b_x_max, b_y_min, b_y_max, b_pix_cnt}, {48'd0, 20'd1});
        frame(4088, 4095, 4090, 4095, 0, 0, -1);

        frame(0, 15, 0, 9, 5, 0, -1);
        frame(0, 15, 0, 9, 5, 0, 4);
        frame(0, 15, 0, 9, 5, 0, -1);
        @(posedge clk); #1;
        chk("after_reset_discard", a_box_valid, 0);
        frame(0, 15, 0, 9, 5, 0, -1);
        @(posedge clk); #1;
        chk("after_reset_valid", a_box_valid, 1);
        chk("after_reset_cnt", a_pix_cnt, 20'd80);

        for (int f = 0; f < 20; f++) begin
            sel = f % 3;
            bx = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(0, 4071) : 4072;
            by = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(0, 4083) : 4084;
            frame(bx, bx + 23, by, by + 11, 4, $urandom_range(0, 40), -1);
        end
        frame(0, 3, 0, 1, 0, 0, -1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drain", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
